// File: rtl/decode_stage_pipelined_if.sv
// Bundle of IF/WB/EX-facing inputs and ID/EX outputs of the pipelined decode stage.
// master drives the decoder inputs (the surrounding pipeline); slave is the decoder.
interface decode_stage_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 10
);
   logic                  if_valid;
   logic [31:0]           instruc;
   logic [PC_WIDTH-1:0]   current_PC;
   logic                  reg_write;
   logic [4:0]            rw;
   logic [DATA_WIDTH-1:0] busw;
   logic                  ex_valid;
   logic                  ex_mem_read;
   logic                  ex_reg_write;
   logic [4:0]            ex_dest;

   logic                  stall;
   logic                  flush_if;
   logic                  branch_sel;
   logic                  jump_sel;
   logic [PC_WIDTH-1:0]   target_address;
   logic                  idex_valid;
   logic [DATA_WIDTH-1:0] idex_bus_a;
   logic [DATA_WIDTH-1:0] idex_bus_b;
   logic [DATA_WIDTH-1:0] idex_immed_ext;
   logic [4:0]            idex_rs;
   logic [4:0]            idex_rt;
   logic [4:0]            idex_rd;
   logic [3:0]            idex_EX_control;
   logic [1:0]            idex_M_control;
   logic [1:0]            idex_WB_control;

   modport master (
      output if_valid, instruc, current_PC, reg_write, rw, busw,
             ex_valid, ex_mem_read, ex_reg_write, ex_dest,
      input  stall, flush_if, branch_sel, jump_sel, target_address,
             idex_valid, idex_bus_a, idex_bus_b, idex_immed_ext,
             idex_rs, idex_rt, idex_rd, idex_EX_control, idex_M_control, idex_WB_control
   );

   modport slave (
      input  if_valid, instruc, current_PC, reg_write, rw, busw,
             ex_valid, ex_mem_read, ex_reg_write, ex_dest,
      output stall, flush_if, branch_sel, jump_sel, target_address,
             idex_valid, idex_bus_a, idex_bus_b, idex_immed_ext,
             idex_rs, idex_rt, idex_rd, idex_EX_control, idex_M_control, idex_WB_control
   );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Pipelined MIPS/DLX ID stage: register bank, control decode, ID branch/jump, hazard stall, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN makes a same-cycle WB write visible to the reads (write-through).
module decode_stage_pipelined #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 10,
   parameter int NUM_REGS   = 32
) (
   input logic                    clock,
   input logic                    reset,
   decode_stage_pipelined_if.slave bus
);
   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   logic [DATA_WIDTH-1:0] regs [32];
   logic [5:0]            opcode;
   logic [4:0]            rs, rt, rd;
   logic                  wb_en;
   logic [DATA_WIDTH-1:0] bus_a, bus_b, immed_ext;
   logic [3:0]            ex_ctl;
   logic [1:0]            m_ctl, wb_ctl;
   logic                  rt_src, is_branch, is_jump;
   logic                  hz_qual, load_use, branch_hz, stall_int;
   logic                  taken, jump_int;
   logic [PC_WIDTH-1:0]   pc_offset;

   assign opcode    = bus.instruc[31:26];
   assign rs        = bus.instruc[25:21];
   assign rt        = bus.instruc[20:16];
   assign rd        = bus.instruc[15:11];
   assign pc_offset = bus.instruc[PC_WIDTH-1:0];
   assign immed_ext = DATA_WIDTH'($signed(bus.instruc[15:0]));
   assign wb_en     = bus.reg_write && (bus.rw != 5'd0) && (32'(bus.rw) < NUM_REGS);

   // Register bank write port; reset clears every entry and beats a same-edge write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_en) begin
         regs[bus.rw] <= bus.busw;
      end
   end

   // Combinational read ports; r0 and out-of-range indices read zero.
   always_comb begin
      bus_a = '0;
      bus_b = '0;
      if (rs != 5'd0 && 32'(rs) < NUM_REGS) bus_a = regs[rs];
      if (rt != 5'd0 && 32'(rt) < NUM_REGS) bus_b = regs[rt];
`ifdef DECODE_WB_BYPASS_EN
      if (wb_en && bus.rw == rs) bus_a = bus.busw;
      if (wb_en && bus.rw == rt) bus_b = bus.busw;
`endif
   end

   always_comb begin
      ex_ctl = '0;
      m_ctl  = '0;
      wb_ctl = '0;
      rt_src = 1'b0;
      case (opcode)
         OP_R:          begin ex_ctl = 4'b1010; wb_ctl = 2'b10; rt_src = 1'b1; end
         OP_LW:         begin ex_ctl = 4'b0100; m_ctl = 2'b10; wb_ctl = 2'b11; end
         OP_SW:         begin ex_ctl = 4'b0100; m_ctl = 2'b01; rt_src = 1'b1; end
         OP_BEQ, OP_BNE: begin ex_ctl = 4'b0001; rt_src = 1'b1; end
         OP_ADDI:       begin ex_ctl = 4'b0100; wb_ctl = 2'b10; end
         default:       ;
      endcase
   end

   assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
   assign is_jump   = (opcode == OP_J);

   // A branch resolving in ID needs its operands now, so any pending EX write to them stalls.
   assign hz_qual   = bus.if_valid && bus.ex_valid && (bus.ex_dest != 5'd0);
   assign load_use  = hz_qual && bus.ex_mem_read &&
                      ((bus.ex_dest == rs) || (rt_src && bus.ex_dest == rt));
   assign branch_hz = hz_qual && is_branch && bus.ex_reg_write &&
                      ((bus.ex_dest == rs) || (bus.ex_dest == rt));
   assign stall_int = load_use || branch_hz;

   assign taken    = !stall_int && bus.if_valid &&
                     (((opcode == OP_BEQ) && (bus_a == bus_b)) ||
                      ((opcode == OP_BNE) && (bus_a != bus_b)));
   assign jump_int = !stall_int && bus.if_valid && is_jump;

   assign bus.stall          = stall_int;
   assign bus.branch_sel     = taken;
   assign bus.jump_sel       = jump_int;
   assign bus.flush_if       = taken || jump_int;
   assign bus.target_address = is_jump ? pc_offset : (bus.current_PC + pc_offset);

   // ID/EX register: a stalled or invalid slot is captured as an all-zero bubble.
   always_ff @(posedge clock) begin
      if (reset || !bus.if_valid || stall_int) begin
         bus.idex_valid      <= 1'b0;
         bus.idex_bus_a      <= '0;
         bus.idex_bus_b      <= '0;
         bus.idex_immed_ext  <= '0;
         bus.idex_rs         <= '0;
         bus.idex_rt         <= '0;
         bus.idex_rd         <= '0;
         bus.idex_EX_control <= '0;
         bus.idex_M_control  <= '0;
         bus.idex_WB_control <= '0;
      end else begin
         bus.idex_valid      <= 1'b1;
         bus.idex_bus_a      <= bus_a;
         bus.idex_bus_b      <= bus_b;
         bus.idex_immed_ext  <= immed_ext;
         bus.idex_rs         <= rs;
         bus.idex_rt         <= rt;
         bus.idex_rd         <= rd;
         bus.idex_EX_control <= ex_ctl;
         bus.idex_M_control  <= m_ctl;
         bus.idex_WB_control <= wb_ctl;
      end
   end
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: behavioural model checked every cycle plus directed literals.
// Honours DECODE_WB_BYPASS_EN the same way the design does.
module tb_decode_stage_pipelined;
   localparam int DW = 32;
   localparam int PW = 10;

   logic clock = 1'b0;
   logic reset;
   int   assertCount = 0;
   int   failCount   = 0;
   logic modelReady  = 1'b0;

   logic [31:0] modelRegs [32];
   logic        expValid;
   logic [31:0] expBusA, expBusB, expImm;
   logic [4:0]  expRs, expRt, expRd;
   logic [3:0]  expEx;
   logic [1:0]  expM, expWb;

   decode_stage_pipelined_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut_bus ();

   decode_stage_pipelined #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .NUM_REGS(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (dut_bus)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ifv, input logic [31:0] ins, input logic [9:0] pc,
                                input logic wbe, input logic [4:0] wrw, input logic [31:0] wbus,
                                input logic exv, input logic exmr, input logic exrw, input logic [4:0] exd);
      dut_bus.if_valid     = ifv;
      dut_bus.instruc      = ins;
      dut_bus.current_PC   = pc;
      dut_bus.reg_write    = wbe;
      dut_bus.rw           = wrw;
      dut_bus.busw         = wbus;
      dut_bus.ex_valid     = exv;
      dut_bus.ex_mem_read  = exmr;
      dut_bus.ex_reg_write = exrw;
      dut_bus.ex_dest      = exd;
   endtask

   task automatic nextEdge();
      @(posedge clock);
      #1;
   endtask

   // Architectural register read as seen by the instruction currently in ID.
   function automatic logic [31:0] modelRead(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
      if (dut_bus.reg_write && dut_bus.rw == idx) return dut_bus.busw;
`endif
      return modelRegs[idx];
   endfunction

   // Returns {EX, M, WB} control for an opcode.
   function automatic logic [7:0] modelControl(input logic [5:0] op);
      case (op)
         6'h00:        return 8'b1010_00_10;
         6'h23:        return 8'b0100_10_11;
         6'h2B:        return 8'b0100_01_00;
         6'h04, 6'h05: return 8'b0001_00_00;
         6'h08:        return 8'b0100_00_10;
         default:      return 8'h00;
      endcase
   endfunction

   function automatic logic modelStall();
      logic [5:0] op;
      logic [4:0] s, t, d;
      logic       usesRt, isBranch;
      op = dut_bus.instruc[31:26];
      s  = dut_bus.instruc[25:21];
      t  = dut_bus.instruc[20:16];
      d  = dut_bus.ex_dest;
      usesRt   = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
      isBranch = (op == 6'h04) || (op == 6'h05);
      if (!(dut_bus.if_valid && dut_bus.ex_valid && d != 5'd0)) return 1'b0;
      if (dut_bus.ex_mem_read && (d == s || (usesRt && d == t))) return 1'b1;
      if (isBranch && dut_bus.ex_reg_write && (d == s || d == t)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic modelBranch();
      logic [5:0]  op;
      logic [31:0] a, b;
      op = dut_bus.instruc[31:26];
      a  = modelRead(dut_bus.instruc[25:21]);
      b  = modelRead(dut_bus.instruc[20:16]);
      if (modelStall() || !dut_bus.if_valid) return 1'b0;
      return (op == 6'h04 && a == b) || (op == 6'h05 && a != b);
   endfunction

   function automatic logic modelJump();
      return !modelStall() && dut_bus.if_valid && dut_bus.instruc[31:26] == 6'h02;
   endfunction

   // Model state advances on the same edge the design samples.
   always @(posedge clock) begin : modelUpdate
      logic [7:0] ctl;
      if (reset) begin
         for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
         {expValid, expBusA, expBusB, expImm, expRs, expRt, expRd, expEx, expM, expWb} = '0;
         modelReady = 1'b1;
      end else begin
         if (dut_bus.if_valid && !modelStall()) begin
            ctl      = modelControl(dut_bus.instruc[31:26]);
            expValid = 1'b1;
            expBusA  = modelRead(dut_bus.instruc[25:21]);
            expBusB  = modelRead(dut_bus.instruc[20:16]);
            expImm   = 32'($signed(dut_bus.instruc[15:0]));
            expRs    = dut_bus.instruc[25:21];
            expRt    = dut_bus.instruc[20:16];
            expRd    = dut_bus.instruc[15:11];
            {expEx, expM, expWb} = ctl;
         end else begin
            {expValid, expBusA, expBusB, expImm, expRs, expRt, expRd, expEx, expM, expWb} = '0;
         end
         if (dut_bus.reg_write && dut_bus.rw != 5'd0) modelRegs[dut_bus.rw] = dut_bus.busw;
      end
   end

   // Every cycle, mid-period, compare combinational and registered outputs against the model.
   always @(negedge clock) begin : compare
      logic       st, br, jp;
      logic [9:0] tgt;
      if (modelReady) begin
         st = modelStall();
         br = modelBranch();
         jp = modelJump();
         if (jp) tgt = dut_bus.instruc[9:0];
         else    tgt = 10'((int'(dut_bus.current_PC) + int'(dut_bus.instruc[9:0])) % 1024);
         checkOutput("stall", dut_bus.stall, st);
         checkOutput("branch_sel", dut_bus.branch_sel, br);
         checkOutput("jump_sel", dut_bus.jump_sel, jp);
         checkOutput("flush_if", dut_bus.flush_if, br || jp);
         if (br || jp) checkOutput("target_address", dut_bus.target_address, tgt);
         checkOutput("idex_valid", dut_bus.idex_valid, expValid);
         checkOutput("idex_bus_a", dut_bus.idex_bus_a, expBusA);
         checkOutput("idex_bus_b", dut_bus.idex_bus_b, expBusB);
         checkOutput("idex_immed_ext", dut_bus.idex_immed_ext, expImm);
         checkOutput("idex_rs", dut_bus.idex_rs, expRs);
         checkOutput("idex_rt", dut_bus.idex_rt, expRt);
         checkOutput("idex_rd", dut_bus.idex_rd, expRd);
         checkOutput("idex_EX_control", dut_bus.idex_EX_control, expEx);
         checkOutput("idex_M_control", dut_bus.idex_M_control, expM);
         checkOutput("idex_WB_control", dut_bus.idex_WB_control, expWb);
      end
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'($urandom), $urandom, 10'($urandom), 1'($urandom), 5'($urandom), $urandom,
                       1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
         nextEdge();
      end
      checkOutput("reset_idex_valid", dut_bus.idex_valid, 0);
      checkOutput("reset_idex_bus_a", dut_bus.idex_bus_a, 0);
      checkOutput("reset_idex_EX", dut_bus.idex_EX_control, 0);
      checkOutput("reset_idex_WB", dut_bus.idex_WB_control, 0);

      reset = 1'b0;
      applyStimulus(1, rtype(5, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("r5_after_reset", dut_bus.idex_bus_a, 0);

      applyStimulus(0, 0, 0, 1, 3, 32'h0000_00AA, 0, 0, 0, 0);
      nextEdge();
      applyStimulus(0, 0, 0, 1, 0, 32'h0000_00FF, 0, 0, 0, 0);
      nextEdge();
      applyStimulus(1, rtype(3, 3, 1), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("add_bus_a", dut_bus.idex_bus_a, 32'hAA);
      checkOutput("add_bus_b", dut_bus.idex_bus_b, 32'hAA);
      checkOutput("add_EX", dut_bus.idex_EX_control, 4'b1010);
      checkOutput("add_WB", dut_bus.idex_WB_control, 2'b10);
      checkOutput("add_valid", dut_bus.idex_valid, 1);
      applyStimulus(1, rtype(0, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("r0_reads_zero", dut_bus.idex_bus_a, 0);

      applyStimulus(1, rtype(3, 4, 1), 0, 0, 0, 0, 1, 1, 1, 3);
      #1 checkOutput("load_use_stall", dut_bus.stall, 1);
      nextEdge();
      checkOutput("stall_bubble_valid", dut_bus.idex_valid, 0);
      checkOutput("stall_bubble_EX", dut_bus.idex_EX_control, 0);
      applyStimulus(1, rtype(3, 4, 1), 0, 0, 0, 0, 1, 1, 1, 0);
      #1 checkOutput("ex_dest0_no_stall", dut_bus.stall, 0);
      nextEdge();
      checkOutput("ex_dest0_valid", dut_bus.idex_valid, 1);

      applyStimulus(0, 0, 0, 1, 1, 7, 0, 0, 0, 0);
      nextEdge();
      applyStimulus(0, 0, 0, 1, 2, 7, 0, 0, 0, 0);
      nextEdge();
      applyStimulus(1, itype(6'h04, 1, 2, 16'd5), 10'h3FE, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("beq_taken", dut_bus.branch_sel, 1);
      checkOutput("beq_flush", dut_bus.flush_if, 1);
      checkOutput("beq_target_wrap", dut_bus.target_address, 10'h003);
      nextEdge();
      applyStimulus(1, itype(6'h05, 1, 2, 16'd5), 10'h3FE, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("bne_not_taken", dut_bus.branch_sel, 0);
      checkOutput("bne_no_flush", dut_bus.flush_if, 0);
      nextEdge();

      applyStimulus(1, {6'h02, 26'h155}, 10'h010, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("jump_sel", dut_bus.jump_sel, 1);
      checkOutput("jump_target", dut_bus.target_address, 10'h155);
      nextEdge();
      applyStimulus(0, {6'h02, 26'h155}, 10'h010, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("jump_invalid", dut_bus.jump_sel, 0);
      nextEdge();

      applyStimulus(1, itype(6'h04, 1, 2, 16'd5), 10'h100, 0, 0, 0, 1, 0, 1, 2);
      #1 checkOutput("branch_hazard_stall", dut_bus.stall, 1);
      checkOutput("branch_hazard_no_sel", dut_bus.branch_sel, 0);
      nextEdge();

      applyStimulus(1, itype(6'h23, 3, 5, 16'd8), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("lw_M", dut_bus.idex_M_control, 2'b10);
      checkOutput("lw_WB", dut_bus.idex_WB_control, 2'b11);
      checkOutput("lw_imm", dut_bus.idex_immed_ext, 32'd8);
      applyStimulus(1, itype(6'h08, 3, 6, 16'hFFFF), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("addi_neg_imm", dut_bus.idex_immed_ext, 32'hFFFF_FFFF);

      applyStimulus(1, itype(6'h2B, 7, 4, 16'd0), 0, 0, 0, 0, 1, 1, 1, 4);
      #1 checkOutput("sw_rt_load_use", dut_bus.stall, 1);
      nextEdge();
      applyStimulus(1, itype(6'h08, 7, 4, 16'd0), 0, 0, 0, 0, 1, 1, 1, 4);
      #1 checkOutput("addi_rt_not_source", dut_bus.stall, 0);
      nextEdge();

      applyStimulus(1, itype(6'h08, 4, 2, 16'd1), 0, 1, 4, 32'h1234, 0, 0, 0, 0);
      nextEdge();
`ifdef DECODE_WB_BYPASS_EN
      checkOutput("wb_same_cycle", dut_bus.idex_bus_a, 32'h1234);
`else
      checkOutput("wb_same_cycle", dut_bus.idex_bus_a, 32'h0);
`endif
      applyStimulus(1, itype(6'h08, 4, 2, 16'd1), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("wb_next_cycle", dut_bus.idex_bus_a, 32'h1234);

      reset = 1'b1;
      applyStimulus(1, rtype(3, 4, 1), 0, 1, 3, 32'h55, 1, 1, 1, 3);
      nextEdge();
      checkOutput("reset_mid_stall_valid", dut_bus.idex_valid, 0);
      checkOutput("reset_mid_stall_rs", dut_bus.idex_rs, 0);
      reset = 1'b0;
      applyStimulus(1, rtype(3, 0, 1), 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      checkOutput("reset_beats_write", dut_bus.idex_bus_a, 0);

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nextEdge();
      nextEdge();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
